img_stream_loader: RTL and testbench

//  Streaming writer for the packed image bus consumed by the CNN core (img_in).
//  - Accepts one pixel per beat over a valid/ready stream.
//  - Assembles a full INPUT_SIZE x INPUT_SIZE x INPUT_CHANNELS frame and presents it stable with img_valid until acked.
//  - Double-buffered: assembly register + output register, so frame N+1 loads while frame N is held for the network.

---
 rtl/mmnet_pkg.sv | 16 +
 rtl/img_stream_loader_frame_beat_counter.sv | 29 ++
 rtl/img_stream_loader.sv | 106 ++++++++++
 tb/tb_img_stream_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmnet_pkg.sv
// Shared constants and types for the CNN input path: frame geometry, pixel type,
// and a counter-width helper used by the image loader.
package mmnet_pkg;

  localparam int INPUT_SIZE_DEF     = 16;
  localparam int INPUT_CHANNELS_DEF = 1;
  localparam int PX_SIZE_DEF        = 8;

  typedef logic [PX_SIZE_DEF-1:0] px_t;

  // Width of an index counting 0..n-1; a single-beat frame still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_stream_loader_frame_beat_counter.sv
// Modulo-FRAME_BEATS beat index for the image loader; clr wins over inc and
// is_last flags the final beat of a frame.
module frame_beat_counter
  import mmnet_pkg::*;
#(
  parameter int FRAME_BEATS = 256,
  parameter int CW          = cnt_width(FRAME_BEATS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          is_last
);

  assign is_last = (count == CW'(FRAME_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= is_last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/img_stream_loader.sv
// Pixel stream to packed CNN frame loader. Beats fill an assembly register; a
// completed frame is copied to img_out and held with img_valid until img_ack.
module img_stream_loader
  import mmnet_pkg::*;
#(
  parameter int INPUT_SIZE     = INPUT_SIZE_DEF,
  parameter int INPUT_CHANNELS = INPUT_CHANNELS_DEF,
  parameter int PX_SIZE        = PX_SIZE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PX_SIZE-1:0] s_data,
  input  logic               s_last,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_out,
  output logic               img_valid,
  input  logic               img_ack,
  output logic               frame_err
);

  localparam int FRAME_BEATS = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
  localparam int FRAME_W     = FRAME_BEATS * PX_SIZE;
  localparam int CW          = cnt_width(FRAME_BEATS);

  typedef enum logic {FILL, WAIT} state_t;

  // Stream handshake: a beat transfers on any rising edge where s_valid && s_ready.
  // s_ready is registered and is low only while a finished frame waits for the
  // output slot. Output side: img_out is stable while img_valid, released by img_ack.
  state_t               state;
  logic [CW-1:0]        count;
  logic                 is_last;
  logic                 accept;
  logic                 early_last;
  logic                 complete;
  logic                 slot_free;
  logic [FRAME_W-1:0]   asm_q;
  logic [FRAME_W-1:0]   asm_d;

  assign accept     = s_valid && s_ready;
  assign complete   = accept && is_last;
  assign early_last = accept && s_last && !is_last;
  assign slot_free  = !img_valid || img_ack;

  frame_beat_counter #(
    .FRAME_BEATS (FRAME_BEATS),
    .CW          (CW)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (accept),
    .clr     (early_last),
    .count   (count),
    .is_last (is_last)
  );

  // asm_d includes the beat being accepted so the final beat reaches img_out without a bubble.
  always_comb begin
    asm_d = asm_q;
    if (accept) begin
      asm_d[int'(count) * PX_SIZE +: PX_SIZE] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      s_ready   <= 1'b1;
      img_valid <= 1'b0;
      img_out   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= early_last || (complete && !s_last);
      case (state)
        FILL: begin
          if (complete && slot_free) begin
            img_out   <= asm_d;
            img_valid <= 1'b1;
          end else if (complete) begin
            state   <= WAIT;
            s_ready <= 1'b0;
          end else if (img_ack) begin
            img_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (img_ack) begin
            img_out <= asm_q;
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= FILL;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_stream_loader.sv
// Bench for img_stream_loader at 4x4x1, 8-bit pixels: directed corner sequences,
// a vector table, and random traffic against a frame-level reference model.
module tb_img_stream_loader;

  localparam int IS = 4;
  localparam int IC = 1;
  localparam int PX = 8;
  localparam int NB = IS * IS * IC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [PX-1:0] s_data = '0;
  logic s_last = 1'b0;
  logic [IS-1:0][IS-1:0][IC-1:0][PX-1:0] img_out;
  logic img_valid;
  logic img_ack = 1'b0;
  logic frame_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  img_stream_loader #(
    .INPUT_SIZE     (IS),
    .INPUT_CHANNELS (IC),
    .PX_SIZE        (PX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .img_out   (img_out),
    .img_valid (img_valid),
    .img_ack   (img_ack),
    .frame_err (frame_err)
  );

  // Reference model: a frame buffer, a beat index, the held frame and a pending flag.
  logic [PX-1:0]      m_buf[NB];
  int                 m_cnt;
  logic [NB*PX-1:0]   m_img;
  bit                 m_valid;
  bit                 m_pending;
  bit                 m_ready;
  bit                 m_err;

  function automatic logic [NB*PX-1:0] pack_buf();
    logic [NB*PX-1:0] f;
    for (int k = 0; k < NB; k++) f[k*PX +: PX] = m_buf[k];
    return f;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_img = '0; m_valid = 0; m_pending = 0; m_ready = 1; m_err = 0;
  endtask

  task automatic model_step(input bit sv, input logic [PX-1:0] sd, input bit sl, input bit ack);
    bit err;
    err = 0;
    if (m_pending) begin
      if (ack) begin
        m_img = pack_buf();
        m_pending = 0;
      end
    end else if (sv) begin
      m_buf[m_cnt] = sd;
      if (m_cnt == NB - 1) begin
        err = !sl;
        m_cnt = 0;
        if (!m_valid || ack) begin
          m_img = pack_buf();
          m_valid = 1;
        end else begin
          m_pending = 1;
        end
      end else begin
        if (sl) begin
          err = 1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
        if (ack) m_valid = 0;
      end
    end else if (ack) begin
      m_valid = 0;
    end
    m_err = err;
    m_ready = !m_pending;
  endtask

  task automatic chk(input string name, input logic [NB*PX-1:0] act, input logic [NB*PX-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("img_valid", NB*PX'(img_valid), NB*PX'(m_valid));
    chk("s_ready", NB*PX'(s_ready), NB*PX'(m_ready));
    chk("frame_err", NB*PX'(frame_err), NB*PX'(m_err));
    chk("img_out", img_out, m_img);
  endtask

  // Drive on the falling edge, let the model see the same inputs at the rising edge, sample 1ns later.
  task automatic step(input bit sv, input logic [PX-1:0] sd, input bit sl, input bit ack);
    @(negedge clk);
    s_valid = sv; s_data = sd; s_last = sl; img_ack = ack;
    @(posedge clk);
    model_step(sv, sd, sl, ack);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 0; s_last = 0; img_ack = 0; rst_n = 0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic send_frame(input logic [PX-1:0] base, input bit with_last, input bit ack_last);
    for (int i = 0; i < NB; i++)
      step(1, base + PX'(i), with_last && (i == NB - 1), ack_last && (i == NB - 1));
  endtask

  typedef struct {
    bit            sv;
    logic [PX-1:0] sd;
    bit            sl;
    bit            ack;
    bit            e_valid;
    bit            e_ready;
    bit            e_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit sv, sl, ack;
    // Early last on beat 5, then idle and a stray ack with nothing held.
    for (int i = 0; i < 6; i++)
      tbl[i] = '{sv: 1, sd: PX'(8'h70 + i), sl: (i == 5), ack: 0, e_valid: 0, e_ready: 1, e_err: (i == 5)};
    tbl[6] = '{sv: 0, sd: '0, sl: 0, ack: 0, e_valid: 0, e_ready: 1, e_err: 0};
    tbl[7] = '{sv: 0, sd: '0, sl: 0, ack: 1, e_valid: 0, e_ready: 1, e_err: 0};

    do_reset();

    // Frame 1, no ack: one-cycle latency, beat 0 in element [0][0][0].
    send_frame(8'h01, 1, 0);
    chk("t1_valid", NB*PX'(img_valid), NB*PX'(1));
    chk("t1_first_px", NB*PX'(img_out[0][0][0]), NB*PX'(8'h01));
    chk("t1_last_px", NB*PX'(img_out[3][3][0]), NB*PX'(8'h10));

    // Second frame while the first is held: loader stalls until ack.
    send_frame(8'h21, 1, 0);
    chk("t2_stall_ready", NB*PX'(s_ready), NB*PX'(0));
    chk("t2_held_px", NB*PX'(img_out[0][0][0]), NB*PX'(8'h01));
    step(0, '0, 0, 1);
    chk("t2_new_px", NB*PX'(img_out[0][0][0]), NB*PX'(8'h21));
    chk("t2_valid", NB*PX'(img_valid), NB*PX'(1));
    chk("t2_ready", NB*PX'(s_ready), NB*PX'(1));

    // Ack coincides with the final beat of the next frame: no img_valid bubble.
    send_frame(8'h41, 1, 1);
    chk("t3_valid", NB*PX'(img_valid), NB*PX'(1));
    chk("t3_new_px", NB*PX'(img_out[0][0][0]), NB*PX'(8'h41));
    step(0, '0, 0, 0);
    chk("t3_hold_valid", NB*PX'(img_valid), NB*PX'(1));

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].ack);
      chk($sformatf("tbl%0d_valid", i), NB*PX'(img_valid), NB*PX'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ready", i), NB*PX'(s_ready), NB*PX'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_err", i), NB*PX'(frame_err), NB*PX'(tbl[i].e_err));
    end
    send_frame(8'h80, 1, 0);
    chk("t4_clean_first", NB*PX'(img_out[0][0][0]), NB*PX'(8'h80));
    chk("t4_clean_last", NB*PX'(img_out[3][3][0]), NB*PX'(8'h8f));

    // Missing last: error pulse but frame delivered, next frame aligned at beat 0.
    step(0, '0, 0, 1);
    chk("t5_freed", NB*PX'(img_valid), NB*PX'(0));
    send_frame(8'h91, 0, 0);
    chk("t5_err", NB*PX'(frame_err), NB*PX'(1));
    chk("t5_valid", NB*PX'(img_valid), NB*PX'(1));
    chk("t5_last_px", NB*PX'(img_out[3][3][0]), NB*PX'(8'ha0));
    step(0, '0, 0, 1);
    chk("t5_err_clear", NB*PX'(frame_err), NB*PX'(0));
    send_frame(8'ha1, 1, 0);
    chk("t5_next_first", NB*PX'(img_out[0][0][0]), NB*PX'(8'ha1));

    // Reset mid-frame, then mid-WAIT.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, PX'(8'he0 + i), 0, 0);
    do_reset();
    chk("t6_ready", NB*PX'(s_ready), NB*PX'(1));
    send_frame(8'hb1, 1, 0);
    chk("t6_first", NB*PX'(img_out[0][0][0]), NB*PX'(8'hb1));
    send_frame(8'hc1, 1, 0);
    chk("t6_wait_ready", NB*PX'(s_ready), NB*PX'(0));
    do_reset();
    chk("t6_rst_valid", NB*PX'(img_valid), NB*PX'(0));
    chk("t6_rst_img", img_out, '0);
    send_frame(8'hd1, 1, 0);
    chk("t6_after_first", NB*PX'(img_out[0][0][0]), NB*PX'(8'hd1));
    chk("t6_after_last", NB*PX'(img_out[3][3][0]), NB*PX'(8'he0));

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      sv  = ($urandom_range(0, 3) != 0);
      sl  = (m_cnt == NB - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
      ack = ($urandom_range(0, 3) == 0);
      step(sv, PX'($urandom), sl, ack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
